// File: rtl/ydevice_pkg.sv
// ydevice_pkg: shared types and constants for the ydevice receive endpoint.
// FSM state encoding, counter width and a saturating increment helper.
package ydevice_pkg;

  // Width of the receive and error counters.
  localparam int CNT_W = 8;

  // Receive FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ydevice_fifo.sv
// ydevice_fifo: synchronous FIFO with show-ahead read and registered
// full/empty flags. 2^DEPTH entries; occupancy counter is DEPTH+1 bits.
// A read of an empty FIFO is ignored. A write is accepted when not full,
// or when full together with a read in the same cycle.
module ydevice_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  output logic [DW-1:0] rd_dat,
  output logic          empty,
  output logic          full
);

  localparam int N = 1 << DEPTH;
  localparam logic [DEPTH:0] FULL_CNT = {1'b1, {DEPTH{1'b0}}};

  logic [DW-1:0]    mem_q [N];
  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             do_wr, do_rd;

  // Qualify the requests and compute next pointers, occupancy and flags.
  always_comb begin
    do_rd    = rd_en && !empty_q;
    do_wr    = wr_en && (!full_q || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == FULL_CNT);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents need no reset because empty gates the output.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_dat = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty  = empty_q;
  assign full   = full_q;

endmodule

// File: rtl/ydevice.sv
// ydevice: receive-side dummy endpoint for one switch Y port.
// Captures words with a registered one-cycle ack, buffers them in a small
// FIFO, counts them, and (with YDEVICE_SEQCHK_EN defined) checks that the
// data forms an incrementing sequence.
//
// Handshake: the switch holds dat_o with validrx=1 until it sees ackrx.
// A word is captured on the edge ending an IDLE cycle where validrx=1 and
// rd_full=0; ackrx is high for exactly the following cycle, during which the
// switch pops on the closing edge. Nothing is captured in ACK or GAP, so the
// word still on the bus during ACK is never taken twice.
module ydevice
  import ydevice_pkg::*;
#(
  parameter int DW      = 4,
  parameter int DEPTH   = 2,
  parameter int ACK_GAP = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DW-1:0]    dat_o,
  input  logic             validrx,
  output logic             ackrx,
  input  logic             rd_en,
  output logic [DW-1:0]    rd_dat,
  output logic             rd_empty,
  output logic             rd_full,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] GAP_LOAD = (ACK_GAP > 0) ? CNT_W'(ACK_GAP - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;
  logic             capture;

  // Next-state, gap counter and capture decode for the receive FSM.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ack_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (validrx && !rd_full) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (ACK_GAP > 0) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Receive counter wraps naturally at 2^CNT_W.
  always_comb begin
    rx_count_d = rx_count_q;
    if (capture) rx_count_d = rx_count_q + 1'b1;
  end

  // FSM, ack and receive counter registers; reset clears ack asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      ack_q      <= 1'b0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign ackrx     = ack_q;
  assign rx_count  = rx_count_q;
  assign dbg_state = state_q;

  ydevice_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_en  (capture),
    .wr_dat (dat_o),
    .rd_en  (rd_en),
    .rd_dat (rd_dat),
    .empty  (rd_empty),
    .full   (rd_full)
  );

`ifdef YDEVICE_SEQCHK_EN
  logic             seeded_q, seeded_d;
  logic [DW-1:0]    seq_exp_q, seq_exp_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;

  // First capture only seeds; every capture reloads expected as word+1.
  always_comb begin
    seeded_d   = seeded_q;
    seq_exp_d  = seq_exp_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (capture) begin
      seeded_d  = 1'b1;
      seq_exp_d = dat_o + 1'b1;
      if (seeded_q && (dat_o != seq_exp_q)) begin
        err_cnt_d  = sat_inc(err_cnt_q);
        err_flag_d = 1'b1;
      end
    end
  end

  // Sequence checker registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seeded_q   <= 1'b0;
      seq_exp_q  <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      seeded_q   <= seeded_d;
      seq_exp_q  <= seq_exp_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign err_count = err_cnt_q;
  assign err_flag  = err_flag_q;
`else
  assign err_count = '0;
  assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_ydevice.sv
// tb_ydevice: self-checking bench for ydevice. Two instances share clock and
// reset: u_dut (ACK_GAP=0) for the table and corner sequences, u_gap
// (ACK_GAP=3) for the gap timing. Expectations follow YDEVICE_SEQCHK_EN.
module tb_ydevice;

  localparam int DW = 4;

`ifdef YDEVICE_SEQCHK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [DW-1:0] dat;
  logic          validrx;
  logic          rd_en;
  logic          ackrx;
  logic [DW-1:0] rd_dat;
  logic          rd_empty, rd_full;
  logic [7:0]    rx_count, err_count;
  logic          err_flag;
  logic [1:0]    dbg_state;

  logic [DW-1:0] g_dat;
  logic          g_validrx;
  logic          g_rd_en;
  logic          g_ackrx;
  logic [DW-1:0] g_rd_dat;
  logic          g_rd_empty, g_rd_full;
  logic [7:0]    g_rx_count, g_err_count;
  logic          g_err_flag;
  logic [1:0]    g_dbg_state;

  ydevice #(.DW(DW), .DEPTH(2), .ACK_GAP(0)) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .dat_o     (dat),
    .validrx   (validrx),
    .ackrx     (ackrx),
    .rd_en     (rd_en),
    .rd_dat    (rd_dat),
    .rd_empty  (rd_empty),
    .rd_full   (rd_full),
    .rx_count  (rx_count),
    .err_count (err_count),
    .err_flag  (err_flag),
    .dbg_state (dbg_state)
  );

  ydevice #(.DW(DW), .DEPTH(2), .ACK_GAP(3)) u_gap (
    .clk_i     (clk),
    .rst_i     (rst),
    .dat_o     (g_dat),
    .validrx   (g_validrx),
    .ackrx     (g_ackrx),
    .rd_en     (g_rd_en),
    .rd_dat    (g_rd_dat),
    .rd_empty  (g_rd_empty),
    .rd_full   (g_rd_full),
    .rx_count  (g_rx_count),
    .err_count (g_err_count),
    .err_flag  (g_err_flag),
    .dbg_state (g_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    validrx   = 1'b0;
    rd_en     = 1'b0;
    g_validrx = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Switch model: present w until ackrx, then pop on the edge ending ACK.
  task automatic offer(input logic [DW-1:0] w, output int ack_cyc);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    validrx = 1'b1;
    dat     = w;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (ackrx) seen = 1'b1;
      n++;
    end
    ack_cyc = cyc;
    check("ack_seen", 32'(seen), 32'd1);
    if (seen) exp_q.push_back(w);
    @(posedge clk);
    #1 validrx = 1'b0;
  endtask

  // Local reader: pop everything the scoreboard expects and compare.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      check("rd_empty_drain", 32'(rd_empty), 32'd0);
      check("rd_dat", 32'(rd_dat), 32'(exp_q.pop_front()));
      rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      n++;
    end
    @(negedge clk);
    check("rd_empty_after_drain", 32'(rd_empty), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            rst_before;
    logic [DW-1:0] dat;
    logic [7:0]    rx;
    logic [7:0]    err;
    bit            flag;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ack_cyc, prev, n, got;

    dat = '0; validrx = 1'b0; rd_en = 1'b0;
    g_dat = '0; g_validrx = 1'b0; g_rd_en = 1'b1;

    // Basic sequence 3,4,5 then sequence-error 7,8,A,B.
    vecs[0] = '{1'b1, 4'h3, 8'd1, 8'd0, 1'b0};
    vecs[1] = '{1'b0, 4'h4, 8'd2, 8'd0, 1'b0};
    vecs[2] = '{1'b0, 4'h5, 8'd3, 8'd0, 1'b0};
    vecs[3] = '{1'b1, 4'h7, 8'd1, 8'd0, 1'b0};
    vecs[4] = '{1'b0, 4'h8, 8'd2, 8'd0, 1'b0};
    vecs[5] = '{1'b0, 4'hA, 8'd3, SEQ_ON ? 8'd1 : 8'd0, SEQ_ON};
    vecs[6] = '{1'b0, 4'hB, 8'd4, SEQ_ON ? 8'd1 : 8'd0, SEQ_ON};

    // Reset values, sampled while reset is held.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ackrx", 32'(ackrx), 32'd0);
    check("rst_rd_empty", 32'(rd_empty), 32'd1);
    check("rst_rd_full", 32'(rd_full), 32'd0);
    check("rst_rd_dat", 32'(rd_dat), 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    #1 rst = 1'b0;

    // Table-driven sequences.
    prev = -1;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_before) begin
        if (i > 0) drain();
        do_reset();
        prev = -1;
      end
      offer(vecs[i].dat, ack_cyc);
      check("vec_rx_count", 32'(rx_count), 32'(vecs[i].rx));
      check("vec_err_count", 32'(err_count), 32'(vecs[i].err));
      check("vec_err_flag", 32'(err_flag), 32'(vecs[i].flag));
      if (prev >= 0) check("ack_spacing", 32'(ack_cyc - prev), 32'd2);
      prev = ack_cyc;
    end
    drain();
    check("err_flag_sticky", 32'(err_flag), 32'(SEQ_ON));

    // Full FIFO: 4 accepted, 5th held off until one read.
    do_reset();
    for (int i = 0; i < 4; i++) offer(4'(5 + i), ack_cyc);
    check("full_after_4", 32'(rd_full), 32'd1);
    validrx = 1'b1;
    dat     = 4'h9;
    repeat (4) begin
      @(negedge clk);
      check("full_ack_low", 32'(ackrx), 32'd0);
      check("full_flag_held", 32'(rd_full), 32'd1);
    end
    check("full_rx_count", 32'(rx_count), 32'd4);
    check("full_head", 32'(rd_dat), 32'(exp_q.pop_front()));
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    @(negedge clk);
    check("full_cleared", 32'(rd_full), 32'd0);
    check("full_idle_no_ack", 32'(ackrx), 32'd0);
    @(negedge clk);
    check("full_ack_5th", 32'(ackrx), 32'd1);
    if (ackrx) exp_q.push_back(4'h9);
    @(posedge clk);
    #1 validrx = 1'b0;
    check("full_rx_count_5", 32'(rx_count), 32'd5);
    drain();

    // Reset during ACK: ackrx drops without a clock edge.
    do_reset();
    validrx = 1'b1;
    dat     = 4'h3;
    n = 0;
    while (!ackrx && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_ack", 32'(ackrx), 32'd1);
    check("pre_rst_state", 32'(dbg_state), 32'd1);
    check("pre_rst_empty", 32'(rd_empty), 32'd0);
    check("pre_rst_rx", 32'(rx_count), 32'd1);
    rst = 1'b1;
    #1;
    check("midack_ackrx", 32'(ackrx), 32'd0);
    check("midack_empty", 32'(rd_empty), 32'd1);
    check("midack_full", 32'(rd_full), 32'd0);
    check("midack_rd_dat", 32'(rd_dat), 32'd0);
    check("midack_rx", 32'(rx_count), 32'd0);
    check("midack_err", 32'(err_count), 32'd0);
    check("midack_flag", 32'(err_flag), 32'd0);
    validrx = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    // Seed was cleared: a word that breaks the old sequence only seeds.
    offer(4'h9, ack_cyc);
    check("reseed_err", 32'(err_count), 32'd0);
    check("reseed_rx", 32'(rx_count), 32'd1);
    drain();

    // Gap instance: continuous validrx, acks 2+ACK_GAP apart.
    do_reset();
    g_validrx = 1'b1;
    got  = 0;
    prev = -1;
    n    = 0;
    while (got < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (g_ackrx) begin
        if (prev >= 0) check("gap_spacing", 32'(cyc - prev), 32'd5);
        prev = cyc;
        got++;
        @(posedge clk);
        #1 g_dat = g_dat + 1'b1;
      end
    end
    g_validrx = 1'b0;
    check("gap_ack_count", 32'(got), 32'd4);
    check("gap_rx_count", 32'(g_rx_count), 32'd4);
    check("gap_err_count", 32'(g_err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
